// File: rtl/fast_square_freq_stepper_if.sv
// Frequency-step request and synthesizer serial-bus signals between the sweep
// controller side (master) and the stepper (slave).
interface fast_square_freq_stepper_if;
  logic        freq_step;
  logic        freq_step_reset;
  logic [15:0] n_word;
  logic        busy;
  logic        overrun;
  logic        syn_data;
  logic        syn_clk;
  logic        syn_le;

  modport master (
    output freq_step, freq_step_reset,
    input  n_word, busy, overrun, syn_data, syn_clk, syn_le
  );

  modport slave (
    input  freq_step, freq_step_reset,
    output n_word, busy, overrun, syn_data, syn_clk, syn_le
  );
endinterface

// File: rtl/fast_square_freq_stepper.sv
// Turns freq_step edges into PLL N-divider updates and shifts each 24-bit
// {N, address} word MSB first into the synthesizer, ending with a latch pulse.
module fast_square_freq_stepper #(
  parameter logic [15:0] N_START  = 16'd100,
  parameter logic [15:0] N_STEP   = 16'd4,
  parameter logic [15:0] N_MAX    = 16'd244,
  parameter logic [7:0]  REG_ADDR = 8'h01,
  parameter int          CLK_DIV  = 4
) (
  input logic                        clock,
  input logic                        reset,
  fast_square_freq_stepper_if.slave  bus
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [4:0] BIT_LAST = 5'd23;

  typedef enum logic [2:0] {IDLE, LOAD, CLK_LO, CLK_HI, LATCH} state_t;

  state_t      state;
  logic        step_d;
  logic        pending;
  logic        pend_reload;
  logic        kind;
  logic [7:0]  div_cnt;
  logic [4:0]  bit_cnt;
  logic [23:0] sr;
  logic [15:0] n_word;
  logic [15:0] n_next;
  logic        busy;
  logic        overrun;
  logic        syn_data;
  logic        syn_clk;
  logic        syn_le;
  logic        rise;
  logic        div_done;

  // Wrap back to the start value past the last legal N; the sum is kept in
  // 17 bits so a large N_STEP cannot alias below N_MAX.
  function automatic logic [15:0] step_n(input logic [15:0] cur, input logic reload);
    logic [16:0] sum;
    sum = {1'b0, cur} + {1'b0, N_STEP};
    if (reload || (sum > {1'b0, N_MAX}))
      step_n = N_START;
    else
      step_n = sum[15:0];
  endfunction

  assign rise     = bus.freq_step & ~step_d;
  assign div_done = (div_cnt == DIV_LAST);

  always_comb begin
    n_next = step_n(n_word, kind);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      step_d      <= 1'b0;
      pending     <= 1'b0;
      pend_reload <= 1'b0;
      kind        <= 1'b0;
      div_cnt     <= 8'd0;
      bit_cnt     <= 5'd0;
      n_word      <= N_START;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      syn_data    <= 1'b0;
      syn_clk     <= 1'b0;
      syn_le      <= 1'b0;
    end else begin
      step_d <= bus.freq_step;
      case (state)
        IDLE: begin
          // busy is held through this cycle when a queued request follows,
          // so back-to-back transactions show one continuous busy.
          if (rise || pending) begin
            state   <= LOAD;
            pending <= 1'b0;
            kind    <= rise ? bus.freq_step_reset : pend_reload;
            if (rise && pending)
              overrun <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        LOAD: begin
          n_word   <= n_next;
          busy     <= 1'b1;
          syn_data <= n_next[15];
          bit_cnt  <= 5'd0;
          div_cnt  <= 8'd0;
          state    <= CLK_LO;
        end
        CLK_LO: begin
          if (div_done) begin
            div_cnt <= 8'd0;
            syn_clk <= 1'b1;
            state   <= CLK_HI;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        CLK_HI: begin
          if (div_done) begin
            div_cnt <= 8'd0;
            syn_clk <= 1'b0;
            if (bit_cnt == BIT_LAST) begin
              syn_data <= 1'b0;
              syn_le   <= 1'b1;
              state    <= LATCH;
            end else begin
              syn_data <= sr[22];
              bit_cnt  <= bit_cnt + 5'd1;
              state    <= CLK_LO;
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        LATCH: begin
          if (div_done) begin
            div_cnt <= 8'd0;
            syn_le  <= 1'b0;
            state   <= IDLE;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase

      // Requests arriving mid-transaction queue one deep; the newest wins.
      if ((state != IDLE) && rise) begin
        if (pending)
          overrun <= 1'b1;
        pending     <= 1'b1;
        pend_reload <= bus.freq_step_reset;
      end
    end
  end

  // Shift register rotates so every bit is consumed; only sr[22] is ever shown.
  always_ff @(posedge clock) begin
    if (state == LOAD)
      sr <= {n_next, REG_ADDR};
    else if ((state == CLK_HI) && div_done)
      sr <= {sr[22:0], sr[23]};
  end

  assign bus.n_word   = n_word;
  assign bus.busy     = busy;
  assign bus.overrun  = overrun;
  assign bus.syn_data = syn_data;
  assign bus.syn_clk  = syn_clk;
  assign bus.syn_le   = syn_le;

endmodule

// File: tb/tb_fast_square_freq_stepper.sv
// Bench for fast_square_freq_stepper: table of step requests with a word
// scoreboard fed at drive time and drained by a serial-bus monitor.
module tb_fast_square_freq_stepper;

  localparam int CLK_DIV = 4;
  localparam int NVEC    = 53;

  typedef struct {
    logic        reload;
    logic [15:0] exp_n;
    logic [23:0] exp_word;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  fast_square_freq_stepper_if bus ();

  fast_square_freq_stepper dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int          tests = 0;
  int          fails = 0;
  logic [23:0] exp_q[$];
  vec_t        vecs[NVEC];

  int          nbits = 0;
  int          le_len = 0;
  int          n_latch = 0;
  int          data_glitch = 0;
  logic [23:0] cap = '0;
  logic        prev_clk = 1'b0;
  logic        prev_le = 1'b0;
  logic        prev_data = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_busy(input logic val, input int budget, input string name);
    int n = 0;
    while (bus.busy !== val && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(name, 32'(bus.busy), 32'(val));
  endtask

  // Serial-bus monitor: collect bits on syn_clk rises, score at syn_le rise.
  always @(negedge clock) begin
    logic [23:0] w;
    if (reset) begin
      nbits    = 0;
      cap      = '0;
      le_len   = 0;
      prev_clk = 1'b0;
      prev_le  = 1'b0;
      prev_data = 1'b0;
    end else begin
      if (bus.syn_clk && prev_clk && (bus.syn_data !== prev_data))
        data_glitch++;
      if (bus.syn_clk && !prev_clk) begin
        cap = {cap[22:0], bus.syn_data};
        nbits++;
      end
      if (bus.syn_le)
        le_len++;
      if (bus.syn_le && !prev_le) begin
        n_latch++;
        check("bit_count", 32'(nbits), 32'd24);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_latch: got word 0x%06h, expected no transaction", cap);
        end else begin
          w = exp_q.pop_front();
          check("shift_word", 32'(cap), 32'(w));
        end
        nbits = 0;
      end
      if (!bus.syn_le && prev_le) begin
        check("le_len", 32'(le_len), 32'(CLK_DIV));
        le_len = 0;
      end
      prev_clk  = bus.syn_clk;
      prev_le   = bus.syn_le;
      prev_data = bus.syn_data;
    end
  end

  initial begin
    int idle_bad;
    int blen;
    int lat0;
    int n;

    for (int i = 0; i < 36; i++) begin
      vecs[i].reload = 1'b0;
      vecs[i].exp_n  = 16'(104 + 4 * i);
    end
    vecs[36].reload = 1'b0;
    vecs[36].exp_n  = 16'd100;
    for (int i = 37; i < 52; i++) begin
      vecs[i].reload = 1'b0;
      vecs[i].exp_n  = 16'(104 + 4 * (i - 37));
    end
    vecs[52].reload = 1'b1;
    vecs[52].exp_n  = 16'd100;
    for (int i = 0; i < NVEC; i++)
      vecs[i].exp_word = {vecs[i].exp_n, 8'h01};

    bus.freq_step       = 1'b0;
    bus.freq_step_reset = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Reset state and a quiet bus with no requests
    check("rst_n_word", 32'(bus.n_word), 32'd100);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    idle_bad = 0;
    repeat (1000) begin
      @(negedge clock);
      if (bus.syn_clk || bus.syn_data || bus.syn_le || bus.busy)
        idle_bad++;
    end
    check("idle_quiet", 32'(idle_bad), 32'd0);

    // Table: first step, climb to N_MAX, wrap, climb to 160, reload
    for (int i = 0; i < NVEC; i++) begin
      exp_q.push_back(vecs[i].exp_word);
      @(negedge clock);
      bus.freq_step       = 1'b1;
      bus.freq_step_reset = vecs[i].reload;
      @(negedge clock);
      bus.freq_step       = 1'b0;
      bus.freq_step_reset = 1'b0;
      check("busy_t1", 32'(bus.busy), 32'd0);
      @(negedge clock);
      check("busy_t2", 32'(bus.busy), 32'd1);
      blen = 0;
      while (bus.busy && blen < 1000) begin
        blen++;
        @(negedge clock);
      end
      check("busy_len", 32'(blen), 32'd197);
      check("n_word", 32'(bus.n_word), 32'(vecs[i].exp_n));
      check("latch_count", 32'(n_latch), 32'(i + 1));
    end

    // freq_step held high: exactly one request
    lat0 = n_latch;
    exp_q.push_back({16'd104, 8'h01});
    @(negedge clock);
    bus.freq_step = 1'b1;
    repeat (450) @(negedge clock);
    bus.freq_step = 1'b0;
    wait_busy(1'b0, 1000, "held_idle");
    repeat (5) @(negedge clock);
    check("held_one_txn", 32'(n_latch - lat0), 32'd1);
    check("held_n_word", 32'(bus.n_word), 32'd104);

    // freq_step_reset toggling alone does nothing
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      bus.freq_step_reset = ~bus.freq_step_reset;
    end
    bus.freq_step_reset = 1'b0;
    repeat (3) @(negedge clock);
    check("fsr_only_busy", 32'(bus.busy), 32'd0);
    check("fsr_only_n_word", 32'(bus.n_word), 32'd104);

    // Two rises during one transaction: overrun, newest (reload) wins
    lat0 = n_latch;
    exp_q.push_back({16'd108, 8'h01});
    @(negedge clock);
    bus.freq_step = 1'b1;
    @(negedge clock);
    bus.freq_step = 1'b0;
    repeat (20) @(negedge clock);
    bus.freq_step = 1'b1;
    @(negedge clock);
    bus.freq_step = 1'b0;
    repeat (3) @(negedge clock);
    check("ovr_single_pending", 32'(bus.overrun), 32'd0);
    exp_q.push_back({16'd100, 8'h01});
    bus.freq_step       = 1'b1;
    bus.freq_step_reset = 1'b1;
    @(negedge clock);
    bus.freq_step       = 1'b0;
    bus.freq_step_reset = 1'b0;
    @(negedge clock);
    check("ovr_set", 32'(bus.overrun), 32'd1);
    wait_busy(1'b0, 1000, "ovr_idle");
    repeat (400) @(negedge clock);
    check("ovr_two_txn", 32'(n_latch - lat0), 32'd2);
    check("ovr_n_word", 32'(bus.n_word), 32'd100);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("ovr_sticky", 32'(bus.overrun), 32'd1);

    // Reset mid-transaction at bit 10
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("ovr_cleared", 32'(bus.overrun), 32'd0);
    exp_q.push_back({16'd104, 8'h01});
    @(negedge clock);
    bus.freq_step = 1'b1;
    @(negedge clock);
    bus.freq_step = 1'b0;
    n = 0;
    while (nbits < 10 && n < 1000) begin
      @(posedge clock);
      n++;
    end
    check("reach_bit10", 32'(nbits >= 10), 32'd1);
    @(negedge clock);
    lat0 = n_latch;
    reset = 1'b1;
    #1;
    check("mid_rst_syn_clk", 32'(bus.syn_clk), 32'd0);
    check("mid_rst_syn_le", 32'(bus.syn_le), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_n_word", 32'(bus.n_word), 32'd100);
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    repeat (300) @(negedge clock);
    check("mid_rst_no_latch", 32'(n_latch - lat0), 32'd0);
    check("mid_rst_idle_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_n_word_after", 32'(bus.n_word), 32'd100);
    check("data_stable_high", 32'(data_glitch), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
